// File: rtl/map_fetcher.sv
// Map reader for the colorizer: converts DTG pixel coordinates plus a per-frame
// horizontal scroll into map BRAM reads and keeps sideband data aligned with the returned data.
module map_fetcher #(
  parameter int MAP_COLS    = 128,
  parameter int MAP_ROWS    = 64,
  parameter int TILE_SHIFT  = 3,
  parameter int ADDR_WIDTH  = 13,
  parameter int MEM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [11:0]           pixel_row,
  input  logic [11:0]           pixel_column,
  input  logic                  video_on,
  input  logic                  frame_start,
  input  logic                  scroll_load,
  input  logic [11:0]           scroll_x,
  input  logic                  scroll_en,
  input  logic [3:0]            scroll_step,
  output logic [ADDR_WIDTH-1:0] map_addr,
  output logic                  map_rd_en,
  input  logic [1:0]            map_data,
  output logic [1:0]            map_value,
  output logic                  out_of_map,
  output logic [11:0]           world_row,
  output logic [11:0]           world_column,
  output logic                  pix_valid,
  output logic [11:0]           scroll_pos
);

  localparam int WORLD_W = MAP_COLS << TILE_SHIFT;
  localparam int WORLD_H = MAP_ROWS << TILE_SHIFT;
  localparam logic [11:0] W_MASK = 12'(WORLD_W - 1);

  // Pipeline word carried alongside the memory read: {oom, video_on, row, wx}.
  localparam int SW = 26;
  localparam logic [SW-1:0] RESET_WORD = {1'b1, 25'd0};

  logic [11:0]           scroll_reg;
  logic [11:0]           scroll_next;
  logic [11:0]           wx_next;
  logic                  oom_next;
  logic [ADDR_WIDTH-1:0] map_addr_next;
  logic [SW-1:0]         stage_a_next;
  logic [ADDR_WIDTH-1:0] map_addr_reg;
  logic                  map_rd_en_reg;
  logic [SW-1:0]         dly_reg [MEM_LATENCY+1];
  logic [SW-1:0]         aligned;

  // Scroll changes only at frame_start, so a frame is always drawn with one offset.
  always_comb begin
    scroll_next = scroll_reg;
    if (frame_start) begin
      if (scroll_load) begin
        scroll_next = scroll_x & W_MASK;
      end else if (scroll_en) begin
        scroll_next = 12'({1'b0, scroll_reg} + {9'd0, scroll_step}) & W_MASK;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scroll_reg <= '0;
    end else begin
      scroll_reg <= scroll_next;
    end
  end

  // Column add is 13 bits wide; masking to the world width makes the seam wrap seamless.
  always_comb begin
    wx_next  = 12'({1'b0, pixel_column} + {1'b0, scroll_reg}) & W_MASK;
    oom_next = !video_on
             || ({1'b0, pixel_row} >= 13'(WORLD_H))
             || ({1'b0, pixel_column} >= 13'(WORLD_W));
    map_addr_next = '0;
    if (!oom_next) begin
      map_addr_next = ADDR_WIDTH'(32'(pixel_row >> TILE_SHIFT) * MAP_COLS
                                  + 32'(wx_next >> TILE_SHIFT));
    end
    stage_a_next = {oom_next, video_on, pixel_row, wx_next};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      map_addr_reg  <= '0;
      map_rd_en_reg <= 1'b0;
    end else begin
      map_addr_reg  <= map_addr_next;
      map_rd_en_reg <= !oom_next;
    end
  end

  // Index 0 is the stage that issues the read; index MEM_LATENCY meets map_data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i <= MEM_LATENCY; i++) begin
        dly_reg[i] <= RESET_WORD;
      end
    end else begin
      dly_reg[0] <= stage_a_next;
      for (int i = 1; i <= MEM_LATENCY; i++) begin
        dly_reg[i] <= dly_reg[i-1];
      end
    end
  end

  assign aligned      = dly_reg[MEM_LATENCY];
  assign out_of_map   = aligned[25];
  assign pix_valid    = aligned[24];
  assign world_row    = aligned[23:12];
  assign world_column = aligned[11:0];
  assign map_value    = aligned[25] ? 2'b00 : map_data;
  assign map_addr     = map_addr_reg;
  assign map_rd_en    = map_rd_en_reg;
  assign scroll_pos   = scroll_reg;

endmodule

// File: tb/tb_map_fetcher.sv
// Directed bench for map_fetcher: one instance at MEM_LATENCY=1 and one at 3,
// each with a BRAM model whose cell value is the low two address bits.
module tb_map_fetcher;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] pixel_row = '0;
  logic [11:0] pixel_column = '0;
  logic        video_on = 1'b0;
  logic        frame_start = 1'b0;
  logic        scroll_load = 1'b0;
  logic [11:0] scroll_x = '0;
  logic        scroll_en = 1'b0;
  logic [3:0]  scroll_step = '0;

  logic [12:0] map_addr1, map_addr3;
  logic        map_rd_en1, map_rd_en3;
  logic [1:0]  map_data1, map_data3;
  logic [1:0]  map_value1, map_value3;
  logic        out_of_map1, out_of_map3;
  logic [11:0] world_row1, world_row3;
  logic [11:0] world_column1, world_column3;
  logic        pix_valid1, pix_valid3;
  logic [11:0] scroll_pos1, scroll_pos3;

  int checks = 0;
  int fails = 0;

  localparam int RST_T = 500;
  int hcol [0:1023];
  int hscr [0:1023];

  always #5 clk = ~clk;

  map_fetcher #(.MEM_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .pixel_row(pixel_row), .pixel_column(pixel_column),
    .video_on(video_on), .frame_start(frame_start), .scroll_load(scroll_load),
    .scroll_x(scroll_x), .scroll_en(scroll_en), .scroll_step(scroll_step),
    .map_addr(map_addr1), .map_rd_en(map_rd_en1), .map_data(map_data1),
    .map_value(map_value1), .out_of_map(out_of_map1), .world_row(world_row1),
    .world_column(world_column1), .pix_valid(pix_valid1), .scroll_pos(scroll_pos1)
  );

  map_fetcher #(.MEM_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset), .pixel_row(pixel_row), .pixel_column(pixel_column),
    .video_on(video_on), .frame_start(frame_start), .scroll_load(scroll_load),
    .scroll_x(scroll_x), .scroll_en(scroll_en), .scroll_step(scroll_step),
    .map_addr(map_addr3), .map_rd_en(map_rd_en3), .map_data(map_data3),
    .map_value(map_value3), .out_of_map(out_of_map3), .world_row(world_row3),
    .world_column(world_column3), .pix_valid(pix_valid3), .scroll_pos(scroll_pos3)
  );

  logic [1:0] mem [0:8191];
  logic [1:0] p3 [0:2];
  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 2'(i);
  end
  always @(posedge clk) begin
    map_data1 <= mem[map_addr1];
    p3[0] <= mem[map_addr3];
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign map_data3 = p3[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_px(input int row, input int col, input logic von);
    pixel_row    = 12'(row);
    pixel_column = 12'(col);
    video_on     = von;
  endtask

  initial begin
    int e, wx, addr;
    tick();
    tick();
    // Reset state
    chk("rst_scroll_pos", 32'(scroll_pos1), 0);
    chk("rst_map_addr", 32'(map_addr1), 0);
    chk("rst_rd_en", 32'(map_rd_en1), 0);
    chk("rst_oom", 32'(out_of_map1), 1);
    chk("rst_pix_valid", 32'(pix_valid1), 0);
    chk("rst_map_value", 32'(map_value1), 0);
    chk("rst_oom_l3", 32'(out_of_map3), 1);
    reset = 1'b0;

    // 1: basic read, scroll 0
    set_px(16, 40, 1'b1);
    tick();
    chk("t1_map_addr", 32'(map_addr1), 261);
    chk("t1_rd_en", 32'(map_rd_en1), 1);
    tick();
    chk("t1_map_value", 32'(map_value1), 1);
    chk("t1_world_col", 32'(world_column1), 40);
    chk("t1_world_row", 32'(world_row1), 16);
    chk("t1_oom", 32'(out_of_map1), 0);
    chk("t1_pix_valid", 32'(pix_valid1), 1);
    $display("t1 row=16 col=40 addr=261 value=%0d", map_value1);

    // 2: load scroll 1000 while a pixel is in flight; wrap at the world seam
    frame_start = 1'b1; scroll_load = 1'b1; scroll_x = 12'd1000;
    tick();
    frame_start = 1'b0; scroll_load = 1'b0;
    set_px(0, 40, 1'b1);
    chk("t2_scroll_pos", 32'(scroll_pos1), 1000);
    chk("t2_inflight_addr", 32'(map_addr1), 261);
    tick();
    chk("t2_map_addr", 32'(map_addr1), 2);
    chk("t2_inflight_wcol", 32'(world_column1), 40);
    set_px(0, 23, 1'b1);
    tick();
    chk("t2_wcol_wrap", 32'(world_column1), 16);
    chk("t2_value", 32'(map_value1), 2);
    chk("t2_addr_seam", 32'(map_addr1), 127);
    tick();
    chk("t2_wcol_seam", 32'(world_column1), 1023);
    chk("t2_value_seam", 32'(map_value1), 3);
    $display("t2 scroll=1000 col=40 -> wx=16, col=23 -> wx=1023");

    // 3: row beyond the map, then blanking
    set_px(600, 40, 1'b1);
    tick();
    chk("t3_rd_en_row", 32'(map_rd_en1), 0);
    chk("t3_addr_row", 32'(map_addr1), 0);
    set_px(16, 40, 1'b0);
    tick();
    chk("t3_oom_row", 32'(out_of_map1), 1);
    chk("t3_value_row", 32'(map_value1), 0);
    chk("t3_pv_row", 32'(pix_valid1), 1);
    chk("t3_wrow_row", 32'(world_row1), 600);
    chk("t3_rd_en_blank", 32'(map_rd_en1), 0);
    tick();
    chk("t3_oom_blank", 32'(out_of_map1), 1);
    chk("t3_pv_blank", 32'(pix_valid1), 0);
    chk("t3_value_blank", 32'(map_value1), 0);
    $display("t3 row=600 and video_on=0 both out of map");

    // 4: auto-scroll 342 frames of 3 px wraps to 2; also load value taken mod world width
    frame_start = 1'b1; scroll_load = 1'b1; scroll_x = 12'd2000;
    tick();
    chk("t4_load_mod", 32'(scroll_pos1), 976);
    scroll_x = 12'd0;
    tick();
    scroll_load = 1'b0; scroll_en = 1'b1; scroll_step = 4'd3;
    repeat (342) tick();
    frame_start = 1'b0;
    tick();
    chk("t4_autoscroll", 32'(scroll_pos1), 2);
    $display("t4 342 x 3 px -> scroll_pos=%0d", scroll_pos1);

    // 5: load beats auto-advance
    frame_start = 1'b1; scroll_load = 1'b1; scroll_x = 12'd100; scroll_step = 4'd5;
    tick();
    frame_start = 1'b0; scroll_load = 1'b0; scroll_en = 1'b0;
    chk("t5_load_wins", 32'(scroll_pos1), 100);
    $display("t5 load+en -> scroll_pos=%0d", scroll_pos1);

    // 6: column ramp through the latency-3 instance with a mid-stream reset
    for (int t = 0; t < 1024; t++) begin
      if (t >= 4) begin
        e = t - 4;
        if (e + 4 <= RST_T || e > RST_T) begin
          wx = (hcol[e] + hscr[e]) % 1024;
          addr = 3 * 128 + wx / 8;
          chk("t6_oom", 32'(out_of_map3), 0);
          chk("t6_wcol", 32'(world_column3), 32'(wx));
          chk("t6_value", 32'(map_value3), 32'(addr % 4));
        end else begin
          chk("t6_flush_oom", 32'(out_of_map3), 1);
          chk("t6_flush_pv", 32'(pix_valid3), 0);
        end
      end
      if (t >= 1) begin
        e = t - 1;
        if (e != RST_T) begin
          wx = (hcol[e] + hscr[e]) % 1024;
          chk("t6_addr", 32'(map_addr3), 32'(3 * 128 + wx / 8));
        end else begin
          chk("t6_addr_rst", 32'(map_addr3), 0);
        end
      end
      set_px(24, t, 1'b1);
      hcol[t] = t;
      hscr[t] = (t <= RST_T) ? 100 : 0;
      if (t == RST_T) begin
        reset = 1'b1;
        #1;
        chk("t6_async_oom", 32'(out_of_map3), 1);
        chk("t6_async_pv", 32'(pix_valid3), 0);
        chk("t6_async_rd_en", 32'(map_rd_en3), 0);
        chk("t6_async_scroll", 32'(scroll_pos3), 0);
        $display("t6 reset asserted at ramp step %0d", t);
      end
      tick();
      if (t == RST_T) reset = 1'b0;
    end
    $display("t6 ramp 0..1023 at latency 3 done");

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
